// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, FSM states and default latencies.
package mdu_ctrl_pkg;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W          = 8;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder
// for the latched operands of the multiply/divide unit.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  input  logic        is_div,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvsr;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign neg_a = is_signed & a[31];
  assign neg_b = is_signed & b[31];
  assign ea    = {{32{neg_a}}, a};
  assign eb    = {{32{neg_b}}, b};
  assign prod  = ea * eb;

  // Magnitude division keeps 0x80000000 / -1 well defined
  assign mag_a = neg_a ? (~a + 32'd1) : a;
  assign mag_b = neg_b ? (~b + 32'd1) : b;
  assign dvsr  = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_u   = mag_a / dvsr;
  assign r_u   = mag_a % dvsr;

  always_comb begin
    hi = prod[63:32];
    lo = prod[31:0];
    if (is_div) begin
      lo = (neg_a ^ neg_b) ? (~q_u + 32'd1) : q_u;
      hi = neg_a ? (~r_u + 32'd1) : r_u;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide control: FSM, latency counter, operand
// latches, HI/LO registers and pipeline stall generation.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             sgn_q;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             idle;
  logic             go_mul;
  logic             go_div;
  logic             done;
  logic             commit;

  assign idle   = (state == ST_IDLE);
  assign go_mul = idle & start & (op == OP_MULT || op == OP_MULTU);
  assign go_div = idle & start & (op == OP_DIV || op == OP_DIVU);
  assign done   = ~idle & (cnt == '0);
  // Divide by zero burns the full latency but never commits
  assign commit = done & ((state == ST_MUL) | (b_q != 32'd0));

  mdu_arith u_arith (
    .a         (a_q),
    .b         (b_q),
    .is_signed (sgn_q),
    .is_div    (state == ST_DIV),
    .hi        (res_hi),
    .lo        (res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      go_mul:  state_nxt = ST_MUL;
      go_div:  state_nxt = ST_DIV;
      done:    state_nxt = ST_IDLE;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    busy  = ~idle;
    stall = md_use_D & (busy | (start & (op <= OP_DIVU)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (go_mul | go_div) begin
      cnt   <= go_mul ? CNT_W'(MUL_CYCLES - 1)
                      : CNT_W'(DIV_CYCLES - 1);
      a_q   <= A;
      b_q   <= B;
      sgn_q <= ~op[0];
    end else if (busy && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      HI <= res_hi;
      LO <= res_lo;
    end else if (idle & start) begin
      if (op == OP_MTHI) HI <= A;
      if (op == OP_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table plus
// hand sequences for stall, busy-start and reset.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall    (stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Start was set up before this posedge; count busy cycles after it
  task automatic wait_and_check(input string name, input logic [31:0] ehi,
                                input logic [31:0] elo, input int ecyc);
    int n;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({name, "_cyc"}, n, ecyc);
    chk({name, "_hi"}, HI, ehi);
    chk({name, "_lo"}, LO, elo);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    op = v.op;
    A = v.a;
    B = v.b;
    wait_and_check(v.name, v.hi, v.lo, v.cyc);
  endtask

  initial begin
    int bc;
    int sbad;

    vecs[0]  = '{"mult_neg",  3'd0, 32'hFFFFFFFE, 32'h3,
                 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{"multu_max", 3'd1, 32'hFFFFFFFF, 32'h2,
                 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{"div_neg",   3'd2, 32'hFFFFFFF9, 32'h2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"divu_zero", 3'd3, 32'h7, 32'h0,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{"div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF,
                 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{"divu",      3'd3, 32'd100, 32'd7,
                 32'd2, 32'd14, 10};
    vecs[6]  = '{"div_negb",  3'd2, 32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD, 10};
    vecs[7]  = '{"mthi",      3'd4, 32'h12345678, 32'h0,
                 32'h12345678, 32'hFFFFFFFD, 0};
    vecs[8]  = '{"mtlo",      3'd5, 32'hCAFEF00D, 32'h0,
                 32'h12345678, 32'hCAFEF00D, 0};
    vecs[9]  = '{"mult_pos",  3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[10] = '{"mult_m1",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h00000000, 32'h00000001, 5};
    vecs[11] = '{"op_rsvd",   3'd6, 32'hDEADBEEF, 32'h5,
                 32'h00000000, 32'h00000001, 0};
    vecs[12] = '{"div_rem",   3'd2, 32'hFFFFFFF8, 32'd3,
                 32'hFFFFFFFE, 32'hFFFFFFFE, 10};

    reset = 1'b0;
    start = 1'b0;
    op = 3'd0;
    A = '0;
    B = '0;
    md_use_D = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    @(negedge clk);
    reset = 1'b1;
    md_use_D = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Stall window plus a second start while busy
    md_use_D = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    A = 32'h10;
    B = 32'h20;
    #1;
    chk("stall_start", stall, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    bc = 0;
    sbad = 0;
    while (busy && bc < 50) begin
      bc++;
      if (stall !== 1'b1) sbad++;
      start = (bc == 2);
      op = 3'd1;
      A = 32'hFFFFFFFF;
      B = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    #1;
    chk("stall_busy_cyc", bc, 5);
    chk("stall_gaps", sbad, 0);
    chk("stall_after", stall, 0);
    chk("ignored_hi", HI, 32'h0);
    chk("ignored_lo", LO, 32'h200);
    md_use_D = 1'b0;

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1;
    op = 3'd2;
    A = 32'd100;
    B = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    md_use_D = 1'b1;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_busy", busy, 0);
    chk("post_hi", HI, 0);
    chk("post_lo", LO, 0);

    // Release reset together with a start
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    op = 3'd1;
    A = 32'd5;
    B = 32'd6;
    wait_and_check("rel_multu", 32'd0, 32'd30, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
